// File: rtl/adc_spi_sampler.sv
// SPI mode-0 master running one ADC conversion frame per start_sample pulse.
// Optional OVERRUN_DETECT_EN builds the sticky dropped-request flag; otherwise overrun is tied low.
module adc_spi_sampler #(
  parameter int FRAME_BITS = 12,
  parameter int DATA_BITS  = 10,
  parameter int SCLK_DIV   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_sample,
  input  logic                 miso,
  output logic                 sclk,
  output logic                 cs_n,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int HW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);

  if (DATA_BITS > FRAME_BITS || DATA_BITS < 1 || FRAME_BITS < 2 || SCLK_DIV < 1) begin : g_param_check
    $error("adc_spi_sampler: illegal FRAME_BITS/DATA_BITS/SCLK_DIV combination");
  end

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t                 state;
  logic [HW-1:0]          half_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   half_end;
  logic                   shift_en;

  // Capture happens on the clk edge that raises sclk; only the last DATA_BITS bits survive,
  // so the leading null bits fall off the top of the register by themselves.
  assign half_end = (half_cnt == HALF_LAST);
  assign shift_en = half_end &&
                    ((state == SETUP) || (state == SHIFT && !sclk && bit_cnt != BIT_LAST));

  always_ff @(posedge clk) begin
    if (shift_en) begin
      shreg <= DATA_BITS'({shreg, miso});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cs_n         <= 1'b1;
      sclk         <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      half_cnt     <= '0;
      bit_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_sample) begin
            state    <= SETUP;
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            half_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        SETUP: begin
          if (half_end) begin
            state    <= SHIFT;
            sclk     <= 1'b1;
            half_cnt <= '0;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (!half_end) begin
            half_cnt <= half_cnt + 1'b1;
          end else begin
            half_cnt <= '0;
            if (sclk) begin
              sclk <= 1'b0;
            end else if (bit_cnt == BIT_LAST) begin
              state        <= DONE;
              cs_n         <= 1'b1;
              sample       <= shreg;
              sample_valid <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sclk    <= 1'b1;
            end
          end
        end
        DONE: begin
          state        <= IDLE;
          sample_valid <= 1'b0;
          busy         <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OVERRUN_DETECT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (start_sample && busy) begin
      overrun <= 1'b1;
    end
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: two instances (SCLK_DIV=1 and 2), behavioural ADC and frame-timing model.
module tb_adc_spi_sampler;

  localparam int F  = 12;
  localparam int DB = 10;
`ifdef OVERRUN_DETECT_EN
  localparam bit OVR_ON = 1'b1;
`else
  localparam bit OVR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    st, miso, sclk, cs_n, vld, busy, ovr;
  logic [DB-1:0] smp [2];
  logic [F-1:0]  word [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adc_spi_sampler #(.FRAME_BITS(F), .DATA_BITS(DB), .SCLK_DIV(1)) dut0 (
    .clk(clk), .reset(reset), .start_sample(st[0]), .miso(miso[0]), .sclk(sclk[0]),
    .cs_n(cs_n[0]), .sample(smp[0]), .sample_valid(vld[0]), .busy(busy[0]), .overrun(ovr[0]));

  adc_spi_sampler #(.FRAME_BITS(F), .DATA_BITS(DB), .SCLK_DIV(2)) dut1 (
    .clk(clk), .reset(reset), .start_sample(st[1]), .miso(miso[1]), .sclk(sclk[1]),
    .cs_n(cs_n[1]), .sample(smp[1]), .sample_valid(vld[1]), .busy(busy[1]), .overrun(ovr[1]));

  // ADC: presents frame bit idx MSB-first, advancing on each sclk falling edge while selected.
  for (genvar g = 0; g < 2; g++) begin : g_adc
    int idx = 0;
    always @(negedge sclk[g] or posedge cs_n[g]) begin
      if (cs_n[g]) idx <= 0;
      else         idx <= idx + 1;
    end
    assign miso[g] = (idx < F) ? word[g][F-1-idx] : 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", nm, a, e, cyc);
    end
  endtask

  // Reference model: a frame is fully described by its start cycle t0.
  int            cyc = 0;
  int            t0 [2];
  bit            act [2];
  logic [DB-1:0] dat [2];
  logic [DB-1:0] esmp [2];
  bit            eovr [2];

  function automatic int div(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int flen(input int i);
    return 2 * div(i) * F + div(i) + 1;
  endfunction

  function automatic bit mbusy(input int i, input int n);
    int d;
    d = n - t0[i];
    return act[i] && d >= 1 && d <= flen(i);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        act[i]  = 1'b0;
        esmp[i] = '0;
        eovr[i] = 1'b0;
      end else begin
        if (act[i] && (cyc + 1 - t0[i]) == flen(i)) esmp[i] = dat[i];
        if (st[i]) begin
          if (mbusy(i, cyc)) begin
            eovr[i] = 1'b1;
          end else begin
            t0[i]  = cyc;
            act[i] = 1'b1;
            dat[i] = word[i][DB-1:0];
          end
        end
      end
    end
    cyc++;
  end

  // Per-cycle comparison against the model plus counters used by the directed checks.
  int vcnt [2], vlast [2], rise [2], cslow [2], shigh [2];
  bit sprev [2];

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      int d, D, L;
      bit b, e_cs, e_sclk, e_vld;
      D = div(i);
      L = flen(i);
      d = cyc - t0[i];
      b = mbusy(i, cyc);
      e_cs   = !(b && d <= L - 1);
      e_sclk = b && d >= D + 1 && d <= D + 2 * D * F && ((d - D - 1) % (2 * D)) < D;
      e_vld  = b && d == L;
      chk($sformatf("cs_n%0d", i), 32'(cs_n[i]), 32'(e_cs));
      chk($sformatf("sclk%0d", i), 32'(sclk[i]), 32'(e_sclk));
      chk($sformatf("valid%0d", i), 32'(vld[i]), 32'(e_vld));
      chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(b));
      chk($sformatf("sample%0d", i), 32'(smp[i]), 32'(esmp[i]));
      chk($sformatf("overrun%0d", i), 32'(ovr[i]), 32'(eovr[i] & OVR_ON));
      if (vld[i] === 1'b1) begin
        vcnt[i]++;
        vlast[i] = cyc;
      end
      if (sclk[i] === 1'b1 && !sprev[i]) rise[i]++;
      if (sclk[i] === 1'b1) shigh[i]++;
      if (cs_n[i] === 1'b0) cslow[i]++;
      sprev[i] = (sclk[i] === 1'b1);
    end
  end

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      vcnt[i] = 0; vlast[i] = -1; rise[i] = 0; cslow[i] = 0; shigh[i] = 0;
    end
  endtask

  task automatic pulse(input int i, output int t);
    @(negedge clk);
    st[i] = 1'b1;
    t = cyc;
    @(negedge clk);
    st[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t;
    reset = 1'b1;
    st = 2'b00;
    word[0] = '0;
    word[1] = '0;
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; t0[i] = 0; eovr[i] = 1'b0; esmp[i] = '0; dat[i] = '0; sprev[i] = 1'b0;
    end
    clr();
    idle(3);
    chk("rst_cs_n", 32'(cs_n[0]), 32'd1);
    chk("rst_sclk", 32'(sclk[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_sample", 32'(smp[0]), 32'd0);
    chk("rst_overrun", 32'(ovr[0]), 32'd0);
    // Start coincident with reset: no frame
    @(negedge clk); st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0; reset = 1'b0;
    chk("rst_start_busy", 32'(busy[0]), 32'd0);
    idle(4);

    // 1: basic frame
    word[0] = 12'h2A5;
    clr();
    pulse(0, t);
    idle(30);
    chk("t1_valid_cycle", 32'(vlast[0]), 32'(t + 26));
    chk("t1_valid_count", 32'(vcnt[0]), 32'd1);
    chk("t1_sclk_pulses", 32'(rise[0]), 32'd12);
    chk("t1_cs_low", 32'(cslow[0]), 32'd25);
    chk("t1_sample", 32'(smp[0]), 32'h2A5);

    // 2: periodic starts every 30 cycles
    clr();
    for (int p = 0; p < 10; p++) begin
      word[0] = 12'($urandom);
      pulse(0, t);
      idle(28);
    end
    chk("t2_valid_count", 32'(vcnt[0]), 32'd10);
    chk("t2_last_latency", 32'(vlast[0]), 32'(t + 26));
    chk("t2_overrun", 32'(ovr[0]), 32'd0);
    chk("t2_sample", 32'(smp[0]), 32'(word[0][DB-1:0]));

    // 3: extra start during a frame
    word[0] = 12'h0B7;
    clr();
    pulse(0, t);
    idle(8);
    st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    idle(20);
    chk("t3_valid_count", 32'(vcnt[0]), 32'd1);
    chk("t3_valid_cycle", 32'(vlast[0]), 32'(t + 26));
    chk("t3_sample", 32'(smp[0]), 32'h0B7);
    chk("t3_overrun", 32'(ovr[0]), 32'(OVR_ON));

    // 4: reset mid-frame
    word[0] = 12'h3C3;
    clr();
    pulse(0, t);
    idle(10);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("t4_cs_n", 32'(cs_n[0]), 32'd1);
    chk("t4_sclk", 32'(sclk[0]), 32'd0);
    chk("t4_sample", 32'(smp[0]), 32'd0);
    chk("t4_overrun", 32'(ovr[0]), 32'd0);
    idle(30);
    chk("t4_no_valid", 32'(vcnt[0]), 32'd0);
    word[0] = 12'h1C3;
    pulse(0, t);
    idle(30);
    chk("t4_restart_sample", 32'(smp[0]), 32'h1C3);

    // 5: leading ones dropped
    word[0] = 12'hFFF;
    pulse(0, t);
    idle(30);
    chk("t5_all_ones", 32'(smp[0]), 32'h3FF);
    word[0] = 12'hC00;
    pulse(0, t);
    idle(30);
    chk("t5_lead_ones_zero", 32'(smp[0]), 32'h000);

    // 6: SCLK_DIV=2
    word[1] = 12'h155;
    clr();
    pulse(1, t);
    idle(55);
    chk("t6_valid_cycle", 32'(vlast[1]), 32'(t + 51));
    chk("t6_sclk_pulses", 32'(rise[1]), 32'd12);
    chk("t6_sclk_high", 32'(shigh[1]), 32'd24);
    chk("t6_cs_low", 32'(cslow[1]), 32'd50);
    chk("t6_sample", 32'(smp[1]), 32'h155);

    // Random traffic on both instances, with occasional resets
    repeat (4000) begin
      @(negedge clk);
      reset = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < 2; i++) begin
        st[i] = ($urandom_range(0, 24) == 0);
        if (st[i] && !mbusy(i, cyc)) word[i] = 12'($urandom);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    st = 2'b00;
    idle(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
